// File: rtl/mem_boot_loader_pkg.sv
// Shared state encoding and default sizing for the boot loader, the RAM model
// and the core bench.
package mem_boot_loader_pkg;

  localparam int unsigned BOOT_ADDR_W    = 16;
  localparam int unsigned BOOT_MEM_DEPTH = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } boot_state_t;

endpackage

// File: rtl/mem_boot_addr_gen.sv
// Shared address counter: plain index while clearing, LOAD_BASE-offset while
// loading, with terminal-count and overflow flags.
module mem_boot_addr_gen #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              load_mode,
  output logic [ADDR_W-1:0] addr,
  output logic              tc,
  output logic              ovf
);

  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   load_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  // One extra bit keeps the base+count sum from wrapping past the RAM end.
  always_comb begin
    load_addr = (ADDR_W+1)'(LOAD_BASE) + {1'b0, cnt};
    addr      = load_mode ? load_addr[ADDR_W-1:0] : cnt;
    tc        = (cnt == ADDR_W'(MEM_DEPTH - 1));
    ovf       = (load_addr == (ADDR_W+1)'(MEM_DEPTH));
  end

endmodule

// File: rtl/mem_boot_loader.sv
// Boot-time loader: holds the core in reset, optionally clears RAM, then
// streams an image into RAM from LOAD_BASE and releases the core.
module mem_boot_loader
  import mem_boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W    = BOOT_ADDR_W,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       MEM_DEPTH = BOOT_MEM_DEPTH,
  parameter int unsigned       LOAD_BASE = 0,
  parameter bit                CLEAR_EN  = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] load_count
);

  boot_state_t       state;
  logic              can_start;
  logic              gen_clr;
  logic              gen_inc;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_tc;
  logic              gen_ovf;

  always_comb begin
    s_ready   = (state == ST_LOAD);
    can_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    gen_clr   = can_start || (state == ST_CLEAR && gen_tc);
    gen_inc   = (state == ST_CLEAR) || (s_ready && s_valid && !gen_ovf);
  end

  mem_boot_addr_gen #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .LOAD_BASE (LOAD_BASE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (gen_clr),
    .inc       (gen_inc),
    .load_mode (s_ready),
    .addr      (gen_addr),
    .tc        (gen_tc),
    .ovf       (gen_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      load_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= CLEAR_EN ? ST_CLEAR : ST_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            load_count <= '0;
          end else if (state == ST_DONE) begin
            // done/cpu_hold follow one cycle behind the final write
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end
        end
        ST_CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= gen_addr;
          mem_wdata <= CLEAR_VAL;
          if (gen_tc) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            if (gen_ovf) begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              mem_we     <= 1'b1;
              mem_addr   <= gen_addr;
              mem_wdata  <= s_data;
              load_count <= load_count + ADDR_W'(1);
              if (s_last) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two instances (base 0 with clear, base 12 without)
// driven from a scenario table and compared against an array RAM model.
module tb_mem_boot_loader;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [2];
  logic       start   [2];
  logic       s_valid [2];
  logic       s_last  [2];
  logic [7:0] s_data  [2];

  wire        s_ready    [2];
  wire        mem_we     [2];
  wire [15:0] mem_addr   [2];
  wire [7:0]  mem_wdata  [2];
  wire        cpu_hold   [2];
  wire        busy       [2];
  wire        done       [2];
  wire        error      [2];
  wire [15:0] load_count [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_boot_loader #(
      .ADDR_W    (16),
      .DATA_W    (8),
      .MEM_DEPTH (DEPTH),
      .LOAD_BASE ((g == 0) ? 0 : 12),
      .CLEAR_EN  (g == 0),
      .CLEAR_VAL (8'h00)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .start      (start[g]),
      .s_valid    (s_valid[g]),
      .s_ready    (s_ready[g]),
      .s_data     (s_data[g]),
      .s_last     (s_last[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .cpu_hold   (cpu_hold[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .error      (error[g]),
      .load_count (load_count[g])
    );
  end

  int total = 0;
  int bad   = 0;

  int unsigned base_v [2] = '{0, 12};
  bit          clr_v  [2] = '{1'b1, 1'b0};
  logic [7:0]  ram_obs [2][DEPTH];
  logic [7:0]  ram_mdl [2][DEPTH];
  int          wr_cnt [2] = '{0, 0};
  int          wr0    [2] = '{0, 0};
  int          oob = 0;
  logic [7:0]  img [32];
  logic [7:0]  prog_img [9] = '{8'hEA, 8'hA9, 8'h55, 8'h69, 8'h03, 8'h29, 8'hF0, 8'h09, 8'h05};

  typedef struct {
    int k;
    int n;
    int gap;
    bit prog;
    bit detail;
    int exp_cnt;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t tbl [8];

  localparam logic [45:0] RST_VEC = {1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000};

  // Observed RAM: every write strobe seen by the bench lands here.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k] === 1'b1) begin
        wr_cnt[k]++;
        if (mem_addr[k] < 16'(DEPTH)) ram_obs[k][mem_addr[k][3:0]] = mem_wdata[k];
        else oob++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [45:0] out_vec(input int k);
    return {cpu_hold[k], s_ready[k], mem_we[k], mem_addr[k], mem_wdata[k],
            busy[k], done[k], error[k], load_count[k]};
  endfunction

  task automatic start_boot(input int k, input bit detail);
    int w;
    #1;
    wr0[k]     = wr_cnt[k];
    start[k]   = 1'b1;
    s_valid[k] = 1'b1;
    s_data[k]  = 8'hEE;
    s_last[k]  = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check("restart", {cpu_hold[k], done[k], error[k], busy[k], load_count[k]},
          {1'b1, 1'b0, 1'b0, 1'b1, 16'h0000});
    if (clr_v[k]) for (int a = 0; a < DEPTH; a++) ram_mdl[k][a] = 8'h00;
    if (detail) begin
      for (int i = 0; i < DEPTH; i++) begin
        start[k] = (i == 3);
        @(negedge clk);
        check("clear_wr", {mem_we[k], mem_addr[k], mem_wdata[k], cpu_hold[k], busy[k]},
              {1'b1, 16'(i), 8'h00, 1'b1, 1'b1});
      end
      start[k] = 1'b0;
      check("clear_to_load", s_ready[k], 1);
    end else begin
      w = 0;
      while (!s_ready[k] && w < 100) begin
        @(negedge clk);
        w++;
      end
      check("ready_wait", w < 100, 1);
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic load_image(input int k, input int n, input int gap, input int exp_cnt,
                            input bit exp_done, input bit exp_err);
    int i = 0;
    int cyc = 0;
    int ph = 0;
    int mism = 0;
    bit v;
    while (i < n && cyc < 400) begin
      case (gap)
        0: v = 1'b1;
        1: v = (ph % 4 == 0) || (ph % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph++;
      s_valid[k] = v;
      s_data[k]  = img[i];
      s_last[k]  = (i == n - 1);
      if (v && s_ready[k]) i++;
      @(negedge clk);
      cyc++;
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
    check("accept_all", i, n);
    if (exp_done) begin
      check("last_wr", {mem_we[k], mem_addr[k], mem_wdata[k], done[k], cpu_hold[k]},
            {1'b1, 16'(base_v[k] + 32'(n) - 1), img[n-1], 1'b0, 1'b1});
      @(negedge clk);
      check("done_rise", {done[k], cpu_hold[k], mem_we[k]}, 3'b100);
    end else if (exp_err) begin
      check("rej_no_wr", mem_we[k], 0);
    end
    for (int j = 0; j < n; j++)
      if (base_v[k] + 32'(j) < DEPTH) ram_mdl[k][base_v[k] + 32'(j)] = img[j];
    @(negedge clk);
    @(negedge clk);
    #1;
    check("load_count", load_count[k], exp_cnt);
    check("flags", {done[k], error[k], cpu_hold[k], busy[k], s_ready[k]},
          {exp_done, exp_err, !exp_done, 1'b0, 1'b0});
    check("wr_count", wr_cnt[k] - wr0[k], exp_cnt + (clr_v[k] ? DEPTH : 0));
    for (int a = 0; a < DEPTH; a++) if (ram_obs[k][a] !== ram_mdl[k][a]) mism++;
    check("ram", mism, 0);
  endtask

  task automatic fill_img(input bit prog, input int n);
    for (int j = 0; j < n; j++) img[j] = prog ? prog_img[j] : 8'($urandom);
  endtask

  initial begin
    int w;
    tbl[0] = '{0,  9, 0, 1'b1, 1'b1,  9, 1'b1, 1'b0};
    tbl[1] = '{0,  9, 1, 1'b1, 1'b0,  9, 1'b1, 1'b0};
    tbl[2] = '{1,  5, 0, 1'b0, 1'b0,  4, 1'b0, 1'b1};
    tbl[3] = '{1,  4, 2, 1'b0, 1'b0,  4, 1'b1, 1'b0};
    tbl[4] = '{0, 16, 2, 1'b0, 1'b0, 16, 1'b1, 1'b0};
    tbl[5] = '{0, 17, 0, 1'b0, 1'b0, 16, 1'b0, 1'b1};
    tbl[6] = '{1,  1, 2, 1'b0, 1'b0,  1, 1'b1, 1'b0};
    tbl[7] = '{0,  3, 2, 1'b0, 1'b0,  3, 1'b1, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; start[k] = 1'b0; s_valid[k] = 1'b0; s_last[k] = 1'b0; s_data[k] = 8'h00;
      for (int a = 0; a < DEPTH; a++) begin
        ram_obs[k][a] = 8'h5A;
        ram_mdl[k][a] = 8'h5A;
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("rst_a", out_vec(0), RST_VEC);
    check("rst_b", out_vec(1), RST_VEC);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_a", out_vec(0), RST_VEC);
    check("idle_b", out_vec(1), RST_VEC);

    for (int r = 0; r < 8; r++) begin
      fill_img(tbl[r].prog, tbl[r].n);
      start_boot(tbl[r].k, tbl[r].detail);
      load_image(tbl[r].k, tbl[r].n, tbl[r].gap, tbl[r].exp_cnt, tbl[r].exp_done, tbl[r].exp_err);
    end

    // start while loading must not restart the clear
    start_boot(0, 1'b0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("start_in_load", {s_ready[0], busy[0], cpu_hold[0], load_count[0]},
          {1'b1, 1'b1, 1'b1, 16'h0000});
    fill_img(1'b0, 6);
    load_image(0, 6, 2, 6, 1'b1, 1'b0);

    // asynchronous reset in the middle of the clear
    #1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    w = 0;
    while (!(mem_we[0] === 1'b1 && mem_addr[0] == 16'd5) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("reach_addr5", w < 50, 1);
    #2 rst_n[0] = 1'b0;
    #1;
    check("async_rst", out_vec(0), RST_VEC);
    @(negedge clk);
    rst_n[0] = 1'b1;
    fill_img(1'b0, 5);
    start_boot(0, 1'b1);
    load_image(0, 5, 2, 5, 1'b1, 1'b0);

    check("oob_writes", oob, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
Boot-time program loader between a byte-stream source and the system RAM write port. Holds the 6502 core in reset while it optionally clears RAM and then streams a program image into RAM from a base address, one byte per handshake. Releases the core when the image is complete. Successor to hand-poked RAM initialisation: parametrised in width, depth, base address and clear mode, and synthesizable. It supports backpressure, overflow detection and restart.

Parameters:
ADDR_W, 16, width of mem_addr
DATA_W, 8, width of stream and memory data
MEM_DEPTH, 1024, number of RAM locations; valid addresses 0..MEM_DEPTH-1
LOAD_BASE, 0, first address written by the image; requires LOAD_BASE < MEM_DEPTH
CLEAR_EN, 1, 1 = fill the whole RAM with CLEAR_VAL before loading; 0 = skip the fill
CLEAR_VAL, 8'h00, fill value

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a boot sequence; honoured only in IDLE, DONE or ERR
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts a byte this cycle
s_data  in  DATA_W  stream byte
s_last  in  1  marks the final byte of the image
mem_we  out  1  RAM write strobe (RW low equivalent)
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data
cpu_hold  out  1  1 = core held in reset
busy  out  1  state is CLEAR or LOAD
done  out  1  image loaded successfully
error  out  1  image overflowed RAM
load_count  out  ADDR_W  bytes written by the current or most recent load

Behaviour:
- One clock domain. Reset is asynchronous and active-low; ports are clk and rst_n.
- Reset values: state IDLE, cpu_hold=1, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, load_count=0.
- Reset asserted mid-operation aborts immediately to the reset values. A partially written RAM is left as is.
- All outputs are registered except s_ready, which is decoded from the state (1 only in LOAD).
- States:
  - IDLE: start -> CLEAR if CLEAR_EN, otherwise LOAD. load_count is cleared on start.
  - CLEAR: mem_we=1 with mem_wdata=CLEAR_VAL, one address per cycle from 0 to MEM_DEPTH-1. Takes exactly MEM_DEPTH cycles, then -> LOAD.
  - LOAD: handshake is s_valid & s_ready.
    - On a handshake, the next cycle drives mem_we=1, mem_addr=LOAD_BASE+load_count, mem_wdata=s_data, and load_count increments. Write latency is 1 cycle after acceptance.
    - No handshake -> mem_we=0. Stalls of any length are allowed.
    - Handshake with s_last=1 -> DONE after that write.
  - DONE: cpu_hold=0 and done=1 from the cycle after the last write.
  - ERR: entered when a byte is accepted while LOAD_BASE+load_count == MEM_DEPTH. That byte is not written and load_count does not increment. error=1, cpu_hold stays 1, s_ready=0.
- start in DONE or ERR restarts the sequence: cpu_hold=1 and done/error cleared in the cycle after start. start in CLEAR or LOAD is ignored.
- A byte accepted exactly at the last address (LOAD_BASE+load_count == MEM_DEPTH-1) with s_last=1 is legal -> DONE.
- s_valid outside LOAD is ignored; no byte is consumed.
- Address arithmetic is ADDR_W bits unsigned. The overflow compare uses ADDR_W+1 bits so it cannot wrap.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, LOAD, DONE, ERR) and the default MEM_DEPTH/ADDR_W constants shared with ram and core_tb.
- One sub-module is natural: mem_boot_addr_gen, an address counter with a clear/load mode select and terminal-count / overflow flags.
- The top level holds the FSM and the output registers.

Test Plan:
- Reset then start with CLEAR_EN=1 and MEM_DEPTH=16: mem_we high for 16 consecutive cycles at addresses 0..15 with data 00, then s_ready=1. cpu_hold stays 1 throughout.
- Stream EA,A9,55,69,03,29,F0,09,05 with s_last on 05, LOAD_BASE=0, CLEAR_EN=0: RAM[0..8] matches the stream, load_count=9, done=1, cpu_hold=0. A core_tb-style run then executes the program.
- Same stream with s_valid toggling 1,0,0,1 per beat: identical RAM contents, one write per accepted byte, no duplicate writes.
- LOAD_BASE=12, MEM_DEPTH=16, stream of 5 bytes: bytes 1-4 written at addresses 12..15, 5th byte rejected, error=1, load_count=4, cpu_hold=1.
- rst_n pulsed low in the middle of CLEAR at address 5: all outputs return to reset values asynchronously and the state is IDLE. A following start restarts the fill at address 0.
- After DONE, pulse start again: cpu_hold rises the next cycle, done clears, and a second image loads correctly.
